clock_time_ctrl: RTL and testbench
==================================

Name: clock_time_ctrl

Overview:
- Sequencing controller for the digital-clock datapath built from BCD mod-6 and mod-10 digit counters.
- Derives a one-second enable from the system clock and drives the cascaded MM:SS digits: sec_lo mod 10, sec_hi mod 6, min_lo mod 10, min_hi mod 6.
- Runs a RUN / SET_MIN / SET_SEC mode FSM so the user can set the time from two pre-debounced button pulses.
- Sits between the board's button conditioning and the seven-segment display driver.

Parameters:
- DIV, 50000000, system clock cycles per one-second tick; legal range is DIV >= 2. The prescaler width is derived internally as clog2(DIV).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- mode_btn  input  1  single-cycle pulse; advances the mode FSM.
- inc_btn  input  1  single-cycle pulse; increments the field selected by the current set mode.
- sec_lo  output  4  BCD seconds units, 0..9.
- sec_hi  output  4  BCD seconds tens, 0..5.
- min_lo  output  4  BCD minutes units, 0..9.
- min_hi  output  4  BCD minutes tens, 0..5.
- mode  output  2  current state: 0=RUN, 1=SET_MIN, 2=SET_SEC. Encoding 3 is unused.
- tick  output  1  one-cycle pulse each time the time advances in RUN.
- hour_co  output  1  one-cycle pulse when the time rolls over from 59:59 to 00:00.

Behaviour:
- Reset (rst=1, asynchronous): all digits 0, mode=RUN, prescaler=0, tick=0, hour_co=0. All outputs are registered.
- RUN, prescaler:
  - Prescaler counts 0..DIV-1.
  - On the edge where the prescaler equals DIV-1, it returns to 0 and the time advances by one second.
  - tick and hour_co are high during the cycle following that edge, together with the new digit values.
  - The first advance occurs exactly DIV cycles after reset release or after entry to RUN.
- RUN, carry chain (all updates on the same edge):
  - sec_lo 9->0 carries into sec_hi.
  - sec_hi 5->0 (only when sec_lo wraps) carries into min_lo.
  - min_lo 9->0 carries into min_hi.
  - min_hi 5->0 completes the rollover.
  - 59:59 -> 00:00 asserts hour_co for one cycle.
  - Digits never hold values outside their BCD range.
- FSM transitions (only on mode_btn=1): RUN->SET_MIN->SET_SEC->RUN. There is no other way to change state.
  - Leaving RUN: prescaler is cleared and held at 0; no advance occurs on that edge, even if the prescaler was at DIV-1.
  - Entering RUN from SET_SEC: prescaler starts from 0.
- SET_MIN:
  - inc_btn increments minutes 00..59 as a two-digit BCD value; 59 wraps to 00.
  - No carry into seconds, hour_co stays 0, seconds are frozen.
- SET_SEC:
  - inc_btn increments seconds 00..59 the same way; 59 wraps to 00.
  - No carry into minutes, hour_co stays 0, minutes are frozen.
- In SET modes: tick stays 0 and the prescaler stays 0.
- inc_btn in RUN is ignored.
- mode_btn and inc_btn high in the same cycle: mode_btn wins; the increment is discarded and the state advances.
- Held buttons: each cycle with a button high counts as one press. Upstream guarantees single-cycle pulses; the block does not edge-detect.
- rst asserted mid-operation, in any state: immediate return to the reset values. After release, the first tick arrives DIV cycles later.

Test Plan:
- DIV=4, release reset, run 40 cycles -> tick every 4th cycle, first at cycle 4. Display reaches 00:10 after 10 ticks; the sec_lo 9->0 carry sets sec_hi=1 on the same edge.
- DIV=4, preload 59:58 via SET modes, return to RUN, wait 8 cycles -> 59:59, then 00:00 with hour_co=1 for exactly one cycle, aligned with the second tick.
- mode_btn once, inc_btn x61 -> mode=1, minutes go 00..59 then 00, ending at 01. Seconds unchanged, tick=0 throughout.
- From SET_MIN: mode_btn, inc_btn x12, mode_btn -> seconds read 12, mode=0. Next tick after exactly DIV cycles gives 13.
- In RUN, pulse mode_btn on the cycle the prescaler is at DIV-1 -> no advance, mode=1. Same-cycle mode_btn+inc_btn in SET_MIN -> mode=2, minutes unchanged.
- Assert rst asynchronously mid-cycle while in SET_SEC at 34:27 -> all outputs 0 and mode=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_time_ctrl.sv
// MM:SS digital-clock sequencer: one-second prescaler, cascaded BCD digits,
// and a RUN / SET_MIN / SET_SEC mode FSM driven by pre-debounced button pulses.
module clock_time_ctrl #(
    parameter int unsigned DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [3:0] sec_lo,
    output logic [3:0] sec_hi,
    output logic [3:0] min_lo,
    output logic [3:0] min_hi,
    output logic [1:0] mode,
    output logic       tick,
    output logic       hour_co
);

    localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } mode_t;

    mode_t         mode_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    sec_lo_q, sec_hi_q, min_lo_q, min_hi_q;
    logic          tick_q, hour_co_q;

    logic [3:0] sec_lo_inc, sec_hi_inc, min_lo_inc, min_hi_inc;
    logic       sec_carry, min_carry;

    // Each two-digit field incremented as one 00..59 unit; carries are consumed
    // only by the RUN advance, so the SET modes never ripple across fields.
    always_comb begin
        sec_lo_inc = (sec_lo_q == 4'd9) ? 4'd0 : sec_lo_q + 4'd1;
        sec_hi_inc = sec_hi_q;
        if (sec_lo_q == 4'd9)
            sec_hi_inc = (sec_hi_q == 4'd5) ? 4'd0 : sec_hi_q + 4'd1;
        sec_carry  = (sec_lo_q == 4'd9) && (sec_hi_q == 4'd5);

        min_lo_inc = (min_lo_q == 4'd9) ? 4'd0 : min_lo_q + 4'd1;
        min_hi_inc = min_hi_q;
        if (min_lo_q == 4'd9)
            min_hi_inc = (min_hi_q == 4'd5) ? 4'd0 : min_hi_q + 4'd1;
        min_carry  = (min_lo_q == 4'd9) && (min_hi_q == 4'd5);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q    <= RUN;
            presc_q   <= '0;
            sec_lo_q  <= '0;
            sec_hi_q  <= '0;
            min_lo_q  <= '0;
            min_hi_q  <= '0;
            tick_q    <= 1'b0;
            hour_co_q <= 1'b0;
        end else begin
            tick_q    <= 1'b0;
            hour_co_q <= 1'b0;
            case (mode_q)
                RUN: begin
                    if (mode_btn) begin
                        mode_q  <= SET_MIN;
                        presc_q <= '0;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_q  <= '0;
                        tick_q   <= 1'b1;
                        sec_lo_q <= sec_lo_inc;
                        sec_hi_q <= sec_hi_inc;
                        if (sec_carry) begin
                            min_lo_q <= min_lo_inc;
                            min_hi_q <= min_hi_inc;
                        end
                        hour_co_q <= sec_carry && min_carry;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                SET_MIN: begin
                    presc_q <= '0;
                    if (mode_btn) begin
                        mode_q <= SET_SEC;
                    end else if (inc_btn) begin
                        min_lo_q <= min_lo_inc;
                        min_hi_q <= min_hi_inc;
                    end
                end
                SET_SEC: begin
                    presc_q <= '0;
                    if (mode_btn) begin
                        mode_q <= RUN;
                    end else if (inc_btn) begin
                        sec_lo_q <= sec_lo_inc;
                        sec_hi_q <= sec_hi_inc;
                    end
                end
                default: begin
                    mode_q  <= RUN;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign sec_lo  = sec_lo_q;
    assign sec_hi  = sec_hi_q;
    assign min_lo  = min_lo_q;
    assign min_hi  = min_hi_q;
    assign mode    = mode_q;
    assign tick    = tick_q;
    assign hour_co = hour_co_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Self-checking bench for clock_time_ctrl: directed scenarios plus random button
// traffic, checked against a seconds-count reference model.
module tb_clock_time_ctrl;

    localparam int unsigned DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic [3:0] sec_lo, sec_hi, min_lo, min_hi;
    logic [1:0] mode;
    logic       tick, hour_co;

    logic [19:0] obs;
    assign obs = {min_hi, min_lo, sec_hi, sec_lo, mode, tick, hour_co};

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: time as total seconds, mode number, cycles since last advance.
    int m_t = 0;
    int m_mode = 0;
    int m_cnt = 0;
    bit m_tick = 0;
    bit m_hco = 0;

    clock_time_ctrl #(.DIV(DIV)) dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sec_lo(sec_lo), .sec_hi(sec_hi), .min_lo(min_lo), .min_hi(min_hi),
        .mode(mode), .tick(tick), .hour_co(hour_co)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] exp_vec();
        int mm, ss;
        mm = m_t / 60;
        ss = m_t % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10),
                2'(m_mode), m_tick, m_hco};
    endfunction

    function automatic logic [19:0] time_vec(input int mm, input int ss, input int md,
                                             input bit tk, input bit hc);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 2'(md), tk, hc};
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = 0; m_cnt = 0; m_tick = 0; m_hco = 0;
    endtask

    task automatic model_step(input bit mb, input bit ib);
        int mm, ss;
        mm = m_t / 60;
        ss = m_t % 60;
        m_tick = 0;
        m_hco  = 0;
        case (m_mode)
            0: begin
                if (mb) begin
                    m_mode = 1; m_cnt = 0;
                end else if (m_cnt == int'(DIV) - 1) begin
                    m_cnt = 0;
                    m_t = (m_t + 1) % 3600;
                    m_tick = 1;
                    m_hco = (m_t == 0);
                end else begin
                    m_cnt++;
                end
            end
            1: begin
                if (mb) m_mode = 2;
                else if (ib) m_t = ((mm + 1) % 60) * 60 + ss;
            end
            default: begin
                if (mb) begin
                    m_mode = 0; m_cnt = 0;
                end else if (ib) begin
                    m_t = mm * 60 + (ss + 1) % 60;
                end
            end
        endcase
    endtask

    // One clock: inputs held across the rising edge, outputs sampled 1ns after it.
    task automatic cyc(input bit mb, input bit ib);
        mode_btn = mb;
        inc_btn  = ib;
        @(posedge clk);
        model_step(mb, ib);
        #1;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (obs !== 20'h0) begin
            n_err++;
            $display("FAIL reset_state got=%h want=%h", obs, 20'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_run_count();
        for (int c = 1; c <= 40; c++) begin
            cyc(0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL run_count cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
            if (c == 4) begin
                n_cmp++;
                if (obs !== time_vec(0, 1, 0, 1, 0)) begin
                    n_err++;
                    $display("FAIL first_tick got=%h want=%h", obs, time_vec(0, 1, 0, 1, 0));
                end
            end
        end
        n_cmp++;
        if (obs !== time_vec(0, 10, 0, 1, 0)) begin
            n_err++;
            $display("FAIL ten_seconds got=%h want=%h", obs, time_vec(0, 10, 0, 1, 0));
        end
    endtask

    task automatic test_rollover();
        do_reset();
        cyc(1, 0);
        for (int i = 0; i < 59; i++) cyc(0, 1);
        cyc(1, 0);
        for (int i = 0; i < 58; i++) cyc(0, 1);
        cyc(1, 0);
        n_cmp++;
        if (obs !== time_vec(59, 58, 0, 0, 0)) begin
            n_err++;
            $display("FAIL preload_5958 got=%h want=%h", obs, time_vec(59, 58, 0, 0, 0));
        end
        for (int c = 1; c <= 8; c++) begin
            cyc(0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL rollover cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        n_cmp++;
        if (obs !== time_vec(0, 0, 0, 1, 1)) begin
            n_err++;
            $display("FAIL hour_carry got=%h want=%h", obs, time_vec(0, 0, 0, 1, 1));
        end
        cyc(0, 0);
        n_cmp++;
        if (hour_co !== 1'b0) begin
            n_err++;
            $display("FAIL hour_co_width got=%b want=0", hour_co);
        end
    endtask

    task automatic test_set_min();
        do_reset();
        cyc(1, 0);
        for (int i = 1; i <= 61; i++) begin
            cyc(0, 1);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL set_min inc=%0d got=%h want=%h", i, obs, exp_vec());
            end
        end
        n_cmp++;
        if (obs !== time_vec(1, 0, 1, 0, 0)) begin
            n_err++;
            $display("FAIL set_min_end got=%h want=%h", obs, time_vec(1, 0, 1, 0, 0));
        end
    endtask

    task automatic test_set_sec();
        cyc(1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 1);
        cyc(1, 0);
        n_cmp++;
        if (obs !== time_vec(1, 12, 0, 0, 0)) begin
            n_err++;
            $display("FAIL set_sec_end got=%h want=%h", obs, time_vec(1, 12, 0, 0, 0));
        end
        for (int c = 1; c <= int'(DIV); c++) begin
            cyc(0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL set_sec_resume cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
        n_cmp++;
        if (obs !== time_vec(1, 13, 0, 1, 0)) begin
            n_err++;
            $display("FAIL resume_tick got=%h want=%h", obs, time_vec(1, 13, 0, 1, 0));
        end
    endtask

    task automatic test_mode_at_wrap();
        for (int c = 1; c < int'(DIV); c++) cyc(0, 0);
        cyc(1, 0);
        n_cmp++;
        if (obs !== time_vec(1, 13, 1, 0, 0)) begin
            n_err++;
            $display("FAIL mode_at_wrap got=%h want=%h", obs, time_vec(1, 13, 1, 0, 0));
        end
    endtask

    task automatic test_same_cycle();
        cyc(1, 1);
        n_cmp++;
        if (obs !== time_vec(1, 13, 2, 0, 0)) begin
            n_err++;
            $display("FAIL same_cycle got=%h want=%h", obs, time_vec(1, 13, 2, 0, 0));
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cyc(1, 0);
        for (int i = 0; i < 34; i++) cyc(0, 1);
        cyc(1, 0);
        for (int i = 0; i < 27; i++) cyc(0, 1);
        n_cmp++;
        if (obs !== time_vec(34, 27, 2, 0, 0)) begin
            n_err++;
            $display("FAIL preload_3427 got=%h want=%h", obs, time_vec(34, 27, 2, 0, 0));
        end
        #3;
        rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== 20'h0) begin
            n_err++;
            $display("FAIL async_reset got=%h want=%h", obs, 20'h0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 1; c <= int'(DIV); c++) begin
            cyc(0, 0);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", c, obs, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        bit mb, ib;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            mb = ($urandom_range(0, 11) == 0);
            ib = ($urandom_range(0, 2) == 0);
            cyc(mb, ib);
            n_cmp++;
            if (obs !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc=%0d mb=%0b ib=%0b got=%h want=%h",
                         c, mb, ib, obs, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_run_count();
        test_rollover();
        test_set_min();
        test_set_sec();
        test_mode_at_wrap();
        test_same_cycle();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
